// File: rtl/fifo_param_pkg.sv
// Shared FIFO definitions: occupancy-state encoding and a small count helper.
package fifo_param_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    NORMAL = 2'b01,
    FULL   = 2'b10
  } fifo_state_t;

  // One step of the occupancy counter; caller guarantees no over/underrun.
  function automatic logic [7:0] next_count(input logic [7:0] cnt,
                                            input logic       inc,
                                            input logic       dec);
    return cnt + {7'd0, inc} - {7'd0, dec};
  endfunction

endpackage

// File: rtl/fifo_param_reg_file.sv
// FIFO storage: 1 write port, 1 registered read port; read data holds when not read.
// The array itself is never reset, only the output register is.
module fifo_param_reg_file #(
  parameter int B = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_addr,
  input  logic [B-1:0] wr_data,
  input  logic         rd_en,
  input  logic [W-1:0] rd_addr,
  output logic [B-1:0] rd_data
);

  logic [B-1:0] mem [2**W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Same-address read+write (full FIFO) returns the old word: the oldest entry.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-flags and sticky errors.
// Read latency 1 (rd_valid pulse); status flags are decoded from registered state only.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int B      = 8,
  parameter int W      = 2,
  parameter int AF_LVL = 3,
  parameter int AE_LVL = 1
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         wr_en,
  input  logic [B-1:0] wr_data,
  input  logic         rd_en,
  output logic [B-1:0] rd_data,
  output logic         rd_valid,
  output logic [W:0]   count,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic         overflow,
  output logic         underflow,
  input  logic         clr_err
);

  localparam int         D      = 2**W;
  localparam logic [W:0] D_CNT  = (W+1)'(D);
  localparam logic [W:0] AF_CNT = (W+1)'(AF_LVL);
  localparam logic [W:0] AE_CNT = (W+1)'(AE_LVL);

  fifo_state_t  state;
  logic [W-1:0] w_addr, r_addr;
  logic [W:0]   count_next;
  logic [7:0]   count_ext;
  logic         wr_acc, rd_acc;

  assign wr_acc     = wr_en & (~full | rd_en);
  assign rd_acc     = rd_en & ~empty;
  assign count_ext  = next_count(8'(count), wr_acc, rd_acc);
  assign count_next = count_ext[W:0];

  assign full         = (state == FULL);
  assign empty        = (state == EMPTY);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  fifo_param_reg_file #(.B(B), .W(W)) u_reg_file (
    .clk     (clk),
    .n_reset (n_reset),
    .wr_en   (wr_acc),
    .wr_addr (w_addr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (r_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      w_addr    <= '0;
      r_addr    <= '0;
      count     <= '0;
      state     <= EMPTY;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) w_addr <= w_addr + 1'b1;
      if (rd_acc) r_addr <= r_addr + 1'b1;
      count    <= count_next;
      rd_valid <= rd_acc;
      // A new error event outranks a same-cycle clear.
      overflow  <= (wr_en & full & ~rd_en) | (overflow & ~clr_err);
      underflow <= (rd_en & empty) | (underflow & ~clr_err);

      case (state)
        EMPTY:   if (wr_acc) state <= (D == 1) ? FULL : NORMAL;
        NORMAL:  if (count_next == D_CNT) state <= FULL;
                 else if (count_next == '0) state <= EMPTY;
        FULL:    if (rd_acc & ~wr_acc) state <= (D == 1) ? EMPTY : NORMAL;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
